stopwatch_counter: RTL

Timekeeping core of the stopwatch. It turns debounced button levels into run, pause, clear and adjust actions, and divides the system clock down to a one-second tick. It maintains the elapsed-seconds value `count` (0–5999, i.e. 00:00–99:59). That value feeds directly into the display stage, which splits it into MM:SS digits and segment patterns.

---
 rtl/stopwatch_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: button edge detection, run/stop/adjust control,
// one-second prescaler and the elapsed-seconds counter with MM:SS adjust arithmetic.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned MAX_COUNT = 5999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_inc,
    input  logic        adj_en,
    input  logic        adj_sel,
    output logic [12:0] count,
    output logic        running,
    output logic        adjusting,
    output logic        tick,
    output logic        wrap,
    output logic        blink
);

    localparam int unsigned     PreW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PreW-1:0] PreLast   = PreW'(TICK_DIV - 1);
    localparam logic [PreW-1:0] BlinkLast = PreW'(TICK_DIV / 2 - 1);
    localparam logic [12:0]     CntLast   = 13'(MAX_COUNT);
    localparam logic [12:0]     MinWrap   = 13'(MAX_COUNT - 59);

    typedef enum logic [1:0] {StStop, StRun, StAdj} state_e;

    state_e          state_q, state_d;
    logic            start_q, clear_q, inc_q;
    logic [PreW-1:0] pre_q, pre_d;
    logic [PreW-1:0] blink_cnt_q, blink_cnt_d;
    logic [12:0]     count_q, count_d;
    logic            running_q, running_d;
    logic            adjusting_q, adjusting_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            blink_q, blink_d;
    logic            start_ev, clear_ev, inc_ev, boundary;

    always_comb begin
        start_ev = btn_start & ~start_q;
        clear_ev = btn_clear & ~clear_q;
        inc_ev   = btn_inc & ~inc_q;

        state_d = state_q;
        unique case (state_q)
            StStop: begin
                if (start_ev) begin
                    state_d = StRun;
                end else if (adj_en) begin
                    state_d = StAdj;
                end
            end
            StRun:   if (start_ev) state_d = StStop;
            StAdj:   if (!adj_en) state_d = StStop;
            default: state_d = StStop;
        endcase

        boundary = (state_q == StRun) && (pre_q == PreLast);

        // Prescaler only advances while staying in RUN, so any exit drops the partial second.
        pre_d = '0;
        if (!clear_ev && (state_q == StRun) && (state_d == StRun) && !boundary) begin
            pre_d = pre_q + 1'b1;
        end

        count_d = count_q;
        if (clear_ev) begin
            count_d = '0;
        end else if (boundary) begin
            count_d = (count_q == CntLast) ? 13'd0 : count_q + 13'd1;
        end else if (inc_ev && (state_q == StAdj)) begin
            if (adj_sel) begin
                count_d = (count_q >= MinWrap) ? count_q - MinWrap : count_q + 13'd60;
            end else begin
                count_d = ((count_q % 13'd60) == 13'd59) ? count_q - 13'd59 : count_q + 13'd1;
            end
        end

        tick_d = boundary & ~clear_ev;
        wrap_d = tick_d & (count_q == CntLast);

        running_d   = (state_d == StRun);
        adjusting_d = (state_d == StAdj);

        // Blink restarts from zero on each entry into ADJ.
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if ((state_q == StAdj) && (state_d == StAdj)) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Previous-level copies track the inputs even in reset: a held button gives no event.
        start_q <= btn_start;
        clear_q <= btn_clear;
        inc_q   <= btn_inc;
        if (!rst_n) begin
            state_q     <= StStop;
            pre_q       <= '0;
            blink_cnt_q <= '0;
            count_q     <= '0;
            running_q   <= 1'b0;
            adjusting_q <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            blink_cnt_q <= blink_cnt_d;
            count_q     <= count_d;
            running_q   <= running_d;
            adjusting_q <= adjusting_d;
            tick_q      <= tick_d;
            wrap_q      <= wrap_d;
            blink_q     <= blink_d;
        end
    end

    assign count     = count_q;
    assign running   = running_q;
    assign adjusting = adjusting_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign blink     = blink_q;

endmodule
